// File: rtl/reductor_8x5.sv
// Narrows signed 8-bit words to 5-bit immediates (saturate or wrap) behind a
// small valid/ready FIFO, tagging out-of-range words and counting them.
module reductor_8x5 #(
  parameter int PROFUNDIDADE = 2,
  parameter int LARGURA_CONT = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    entradaValida,
  output logic                    entradaPronta,
  input  logic [7:0]              sinalEntrada,
  input  logic                    modoSaturar,
  output logic                    saidaValida,
  input  logic                    saidaPronta,
  output logic [4:0]              sinalReduzido,
  output logic                    foraFaixa,
  input  logic                    limparContagem,
  output logic [LARGURA_CONT-1:0] contagemFora
);
  localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam logic [PW:0] OCC_MAX = (PW+1)'(PROFUNDIDADE);

  typedef struct packed {
    logic       fora;
    logic [4:0] val;
  } entry_t;

  entry_t        mem [PROFUNDIDADE];
  entry_t        novo, head_next;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [PW:0]   occ, occ_next;
  logic          push, pop, cheio, vazio;

  // A value fits in 5 signed bits only when bits 7..4 are all copies of the sign.
  always_comb begin
    novo.fora = (sinalEntrada[7:4] != 4'h0) && (sinalEntrada[7:4] != 4'hF);
    novo.val  = sinalEntrada[4:0];
    if (modoSaturar && novo.fora)
      novo.val = sinalEntrada[7] ? 5'b10000 : 5'b01111;
  end

  assign cheio         = (occ == OCC_MAX);
  assign vazio         = (occ == '0);
  assign entradaPronta = !cheio;
  assign saidaValida   = !vazio;
  assign push          = entradaValida && !cheio;
  assign pop           = !vazio && saidaPronta;

  // The head register is reloaded from whatever will sit at rd_next; when that
  // slot is being written this cycle the new word bypasses the array.
  always_comb begin
    occ_next = occ;
    if (push && !pop)
      occ_next = occ + 1'b1;
    else if (pop && !push)
      occ_next = occ - 1'b1;
    rd_next   = pop ? rd_ptr + 1'b1 : rd_ptr;
    head_next = (push && (wr_ptr == rd_next)) ? novo : mem[rd_next];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      sinalReduzido <= '0;
      foraFaixa     <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      occ    <= occ_next;
      if (occ_next != '0) begin
        sinalReduzido <= head_next.val;
        foraFaixa     <= head_next.fora;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= novo;
  end

  always_ff @(posedge clock) begin
    if (reset || limparContagem)
      contagemFora <= '0;
    else if (push && novo.fora && (contagemFora != '1))
      contagemFora <= contagemFora + 1'b1;
  end
endmodule

// File: tb/tb_reductor_8x5.sv
// Directed bench for reductor_8x5: vector table through an empty FIFO, then
// stall/backpressure, streaming, counter clear/saturation and mid-stream reset.
module tb_reductor_8x5;
  logic       clock = 1'b0;
  logic       reset, entradaValida, modoSaturar, saidaPronta, limparContagem;
  logic [7:0] sinalEntrada;
  logic       entradaPronta, saidaValida, foraFaixa;
  logic [4:0] sinalReduzido;
  logic [7:0] contagemFora;
  logic       entradaPronta2, saidaValida2, foraFaixa2;
  logic [4:0] sinalReduzido2;
  logic [1:0] contagemFora2;

  always #5 clock = ~clock;

  reductor_8x5 #(.PROFUNDIDADE(2), .LARGURA_CONT(8)) u_dut (
    .clock(clock), .reset(reset), .entradaValida(entradaValida),
    .entradaPronta(entradaPronta), .sinalEntrada(sinalEntrada),
    .modoSaturar(modoSaturar), .saidaValida(saidaValida),
    .saidaPronta(saidaPronta), .sinalReduzido(sinalReduzido),
    .foraFaixa(foraFaixa), .limparContagem(limparContagem),
    .contagemFora(contagemFora)
  );

  reductor_8x5 #(.PROFUNDIDADE(2), .LARGURA_CONT(2)) u_dut2 (
    .clock(clock), .reset(reset), .entradaValida(entradaValida),
    .entradaPronta(entradaPronta2), .sinalEntrada(sinalEntrada),
    .modoSaturar(modoSaturar), .saidaValida(saidaValida2),
    .saidaPronta(saidaPronta), .sinalReduzido(sinalReduzido2),
    .foraFaixa(foraFaixa2), .limparContagem(limparContagem),
    .contagemFora(contagemFora2)
  );

  typedef struct {
    logic [7:0] din;
    logic       sat;
    logic [4:0] val;
    logic       fora;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int e8 = 0;
  int e2 = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic bump(input logic fora);
    if (fora) begin
      if (e8 < 255) e8++;
      if (e2 < 3) e2++;
    end
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, " cnt8"}, 32'(contagemFora), 32'(e8));
    chk({nm, " cnt2"}, 32'(contagemFora2), 32'(e2));
  endtask

  function automatic logic ref_fora(input logic [7:0] d);
    int s;
    s = int'($signed(d));
    return (s > 15) || (s < -16);
  endfunction

  function automatic logic [4:0] ref_val(input logic [7:0] d, input logic sat);
    int s;
    s = int'($signed(d));
    if (sat && s > 15) return 5'b01111;
    if (sat && s < -16) return 5'b10000;
    return d[4:0];
  endfunction

  initial begin
    vec_t tbl[12];
    logic [7:0] q[$];
    logic [7:0] w;
    tbl[0]  = '{8'h05, 1'b1, 5'b00101, 1'b0};
    tbl[1]  = '{8'h7F, 1'b1, 5'b01111, 1'b1};
    tbl[2]  = '{8'h80, 1'b1, 5'b10000, 1'b1};
    tbl[3]  = '{8'hF0, 1'b1, 5'b10000, 1'b0};
    tbl[4]  = '{8'h23, 1'b0, 5'b00011, 1'b1};
    tbl[5]  = '{8'h0F, 1'b1, 5'b01111, 1'b0};
    tbl[6]  = '{8'h10, 1'b1, 5'b01111, 1'b1};
    tbl[7]  = '{8'hEF, 1'b1, 5'b10000, 1'b1};
    tbl[8]  = '{8'hEF, 1'b0, 5'b01111, 1'b1};
    tbl[9]  = '{8'h80, 1'b0, 5'b00000, 1'b1};
    tbl[10] = '{8'hFF, 1'b1, 5'b11111, 1'b0};
    tbl[11] = '{8'h10, 1'b0, 5'b10000, 1'b1};

    reset = 1'b1; entradaValida = 1'b0; sinalEntrada = '0; modoSaturar = 1'b1;
    saidaPronta = 1'b1; limparContagem = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst saidaValida", 32'(saidaValida), 0);
    chk("rst entradaPronta", 32'(entradaPronta), 1);
    chk("rst sinalReduzido", 32'(sinalReduzido), 0);
    chk("rst foraFaixa", 32'(foraFaixa), 0);
    chk_cnt("rst");

    // Each vector goes through an empty FIFO: visible one cycle after accept.
    for (int i = 0; i < 12; i++) begin
      entradaValida = 1'b1; sinalEntrada = tbl[i].din; modoSaturar = tbl[i].sat;
      tick();
      entradaValida = 1'b0;
      bump(tbl[i].fora);
      chk($sformatf("vec%0d valid", i), 32'(saidaValida), 1);
      chk($sformatf("vec%0d val", i), 32'(sinalReduzido), 32'(tbl[i].val));
      chk($sformatf("vec%0d fora", i), 32'(foraFaixa), 32'(tbl[i].fora));
      chk_cnt($sformatf("vec%0d", i));
      tick();
      chk($sformatf("vec%0d drained", i), 32'(saidaValida), 0);
    end

    // Backpressure: fill, hold third word, one pop, then drain in order.
    saidaPronta = 1'b0; modoSaturar = 1'b1;
    entradaValida = 1'b1; sinalEntrada = 8'h01;
    tick();
    chk("stall head A", 32'(sinalReduzido), 1);
    chk("stall rdy1", 32'(entradaPronta), 1);
    sinalEntrada = 8'h02;
    tick();
    chk("stall full", 32'(entradaPronta), 0);
    chk("stall head A2", 32'(sinalReduzido), 1);
    sinalEntrada = 8'h40;
    tick();
    chk("stall held rdy", 32'(entradaPronta), 0);
    chk("stall head stable", 32'(sinalReduzido), 1);
    chk("stall fora stable", 32'(foraFaixa), 0);
    chk_cnt("stall held");
    saidaPronta = 1'b1;
    tick();
    saidaPronta = 1'b0;
    chk("pop no same-cycle push", 32'(entradaPronta), 1);
    chk("stall head B", 32'(sinalReduzido), 2);
    chk_cnt("stall after pop");
    tick();
    entradaValida = 1'b0;
    bump(1'b1);
    chk("stall C taken", 32'(entradaPronta), 0);
    chk_cnt("stall C");
    saidaPronta = 1'b1;
    tick();
    chk("drain head C", 32'(sinalReduzido), 5'b01111);
    chk("drain fora C", 32'(foraFaixa), 1);
    tick();
    chk("drain empty", 32'(saidaValida), 0);

    // Streaming at occupancy 1: one word in, one word out every cycle.
    saidaPronta = 1'b0; entradaValida = 1'b1; sinalEntrada = 8'h00;
    tick();
    q.push_back(8'h00);
    saidaPronta = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w = 8'(i + 1);
      sinalEntrada = w;
      tick();
      void'(q.pop_front());
      q.push_back(w);
      bump(ref_fora(w));
      chk($sformatf("strm%0d valid", i), 32'(saidaValida), 1);
      chk($sformatf("strm%0d rdy", i), 32'(entradaPronta), 1);
      chk($sformatf("strm%0d val", i), 32'(sinalReduzido), 32'(ref_val(q[0], 1'b1)));
    end
    entradaValida = 1'b0;
    chk("strm fora last", 32'(foraFaixa), 32'(ref_fora(q[0])));
    chk_cnt("strm");
    tick();
    chk("strm drained", 32'(saidaValida), 0);

    // Clear wins over a simultaneous out-of-range accept.
    limparContagem = 1'b1; entradaValida = 1'b1; sinalEntrada = 8'h7F;
    tick();
    limparContagem = 1'b0; entradaValida = 1'b0;
    e8 = 0; e2 = 0;
    chk_cnt("clear");
    sinalEntrada = 8'h90; entradaValida = 1'b1;
    tick();
    entradaValida = 1'b0;
    bump(1'b1);
    chk_cnt("after clear");
    chk("after clear val", 32'(sinalReduzido), 5'b10000);
    tick();

    // Reset with two buffered entries: nothing may emerge afterwards.
    saidaPronta = 1'b0; entradaValida = 1'b1; sinalEntrada = 8'h03;
    tick();
    sinalEntrada = 8'h04;
    tick();
    entradaValida = 1'b0;
    chk("pre-rst full", 32'(entradaPronta), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e8 = 0; e2 = 0;
    chk("midrst valid", 32'(saidaValida), 0);
    chk("midrst rdy", 32'(entradaPronta), 1);
    chk("midrst val", 32'(sinalReduzido), 0);
    chk_cnt("midrst");
    saidaPronta = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst quiet%0d", i), 32'(saidaValida), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
